ins_pair_queue: RTL

INS_PAIR_QUEUE -- requirements
Module: ins_pair_queue

---
 rtl/ins_pair_queue_if.sv | 36 +++
 rtl/ins_pair_queue.sv | 107 ++++++++++
 2 files changed

// File: rtl/ins_pair_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : ins_pair_queue_if
// Brief   : Fetch-side and issue-side signal bundle for the instruction pair queue.
// Revision: 1.0  initial release
// ============================================================================
interface ins_pair_queue_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    FetchValid;
  logic [31:0]   FetchIns0;
  logic [31:0]   FetchIns1;
  logic [31:0]   FetchPC;
  logic          FetchReady;
  logic [1:0]    IssueCnt;
  logic          Flush;
  logic [31:0]   Ins1;
  logic [31:0]   Ins2;
  logic          Ins1Valid;
  logic          Ins2Valid;
  logic [31:0]   Ins1PC;
  logic [CW-1:0] Count;

  modport master (
    output FetchValid, FetchIns0, FetchIns1, FetchPC, IssueCnt, Flush,
    input  FetchReady, Ins1, Ins2, Ins1Valid, Ins2Valid, Ins1PC, Count
  );

  modport slave (
    input  FetchValid, FetchIns0, FetchIns1, FetchPC, IssueCnt, Flush,
    output FetchReady, Ins1, Ins2, Ins1Valid, Ins2Valid, Ins1PC, Count
  );
endinterface
`default_nettype wire

// File: rtl/ins_pair_queue.sv
`default_nettype none
// ============================================================================
// Module  : ins_pair_queue
// Brief   : Circular instruction queue, up to two pushes and two pops per cycle.
// Revision: 1.0  initial release
// ============================================================================
module ins_pair_queue #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  ins_pair_queue_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   word_d [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];

  logic          ready;
  logic [1:0]    issue_clamp;
  logic [1:0]    push_cnt;
  logic [1:0]    pop_cnt;
  logic [AW-1:0] wp_plus1;
  logic [AW-1:0] rp_plus1;
  logic          slot1_valid;
  logic          slot2_valid;

  always_comb begin
    ready       = (count_q <= CW'(DEPTH - 2));
    issue_clamp = bus.IssueCnt[1] ? 2'd2 : {1'b0, bus.IssueCnt[0]};
    wp_plus1    = wp_q + AW'(1);

    // Over-issue is clipped to occupancy, which is then below two.
    pop_cnt = issue_clamp;
    if (CW'(issue_clamp) > count_q) begin
      pop_cnt = count_q[1:0];
    end

    push_cnt = 2'd0;
    if (ready) begin
      case (bus.FetchValid)
        2'b01:   push_cnt = 2'd1;
        2'b11:   push_cnt = 2'd2;
        default: push_cnt = 2'd0;
      endcase
    end

    rp_d    = rp_q + AW'(pop_cnt);
    wp_d    = wp_q + AW'(push_cnt);
    count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
    word_d  = word_q;
    pc_d    = pc_q;

    if (!bus.Flush && push_cnt != 2'd0) begin
      word_d[wp_q] = bus.FetchIns0;
      pc_d[wp_q]   = bus.FetchPC;
      if (push_cnt == 2'd2) begin
        word_d[wp_plus1] = bus.FetchIns1;
        pc_d[wp_plus1]   = bus.FetchPC + 32'd4;
      end
    end

    if (bus.Flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Payload is never reset; occupancy masks stale entries.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    pc_q   <= pc_d;
  end

  assign rp_plus1    = rp_q + AW'(1);
  assign slot1_valid = (count_q >= CW'(1));
  assign slot2_valid = (count_q >= CW'(2));

  assign bus.FetchReady = ready;
  assign bus.Ins1Valid  = slot1_valid;
  assign bus.Ins2Valid  = slot2_valid;
  assign bus.Ins1       = slot1_valid ? word_q[rp_q]     : NOP;
  assign bus.Ins2       = slot2_valid ? word_q[rp_plus1] : NOP;
  assign bus.Ins1PC     = slot1_valid ? pc_q[rp_q]       : 32'd0;
  assign bus.Count      = count_q;
endmodule
`default_nettype wire
